// File: rtl/id_issue_ctrl.sv
// id_issue_ctrl: ID pipeline slot and issue controller.
// Holds the decoded instruction slot and its valid/allowin handshake.
// Resolves source operands through a priority forwarding network.
// Interlocks on pending producer results and on a busy multi-cycle MDU.
// Keeps a saturating count of hazard stall cycles.
module id_issue_ctrl #(
  parameter int unsigned DATA_WD = 32,
  parameter int unsigned IN_WD   = 64,
  parameter int unsigned NSRC    = 2,
  parameter int unsigned NFWD    = 3,
  parameter int unsigned AW      = 5,
  parameter int unsigned MDU_LAT = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    if_to_id_valid,
  input  logic [IN_WD-1:0]        if_to_id_bus,
  output logic                    id_allowin,
  input  logic                    exe_allowin,
  output logic                    id_to_exe_valid,
  output logic [IN_WD-1:0]        id_data,
  input  logic                    flush,
  input  logic [NSRC-1:0]         src_need,
  input  logic [NSRC*AW-1:0]      src_addr,
  input  logic [NSRC*DATA_WD-1:0] src_rdata,
  input  logic                    is_mdu,
  input  logic [AW-1:0]           dst_addr,
  input  logic [NFWD-1:0]         fwd_valid,
  input  logic [NFWD-1:0]         fwd_we,
  input  logic [NFWD*AW-1:0]      fwd_addr,
  input  logic [NFWD*DATA_WD-1:0] fwd_data,
  input  logic [NFWD-1:0]         fwd_pending,
  output logic [NSRC*DATA_WD-1:0] src_data,
  output logic                    id_ready_go,
  output logic [31:0]             stall_cnt
);

  // Counter width for the MDU latency countdown (at least one bit).
  localparam int unsigned CW = (MDU_LAT > 1) ? $clog2(MDU_LAT) : 1;
  localparam logic [CW-1:0] MDU_INIT = CW'(MDU_LAT - 1);

  // Slot state
  logic                    r_id_valid;
  logic [IN_WD-1:0]        r_id_data;

  // MDU scoreboard state
  logic                    r_mdu_busy;
  logic [CW-1:0]           r_mdu_cnt;
  logic [AW-1:0]           r_mdu_dst;

  // Performance counter
  logic [31:0]             r_stall_cnt;

  // Combinational helpers
  logic [NSRC*DATA_WD-1:0] w_src_data;
  logic [NSRC-1:0]         w_hit;
  logic [NSRC-1:0]         w_src_pend;
  logic [NSRC-1:0]         w_src_mdu;
  logic                    w_mdu_active;
  logic                    w_mdu_haz;
  logic                    w_ready_go;
  logic                    w_allowin;
  logic                    w_issue;
  logic                    w_issue_mdu;
  logic                    w_load;

  // The MDU result becomes visible through the normal writeback path in the
  // last busy cycle (count 0), so consumers only wait while the count is
  // non-zero. This is also what lets a back-to-back MDU op issue in the
  // expiry cycle.
  assign w_mdu_active = r_mdu_busy & (r_mdu_cnt != {CW{1'b0}});

  // Per-source operand selection: youngest matching producer wins, r0 and
  // unused sources always take the register file value.
  always_comb begin
    w_src_data = src_rdata;
    w_src_pend = {NSRC{1'b0}};
    w_hit      = {NSRC{1'b0}};
    for (int i = 0; i < NSRC; i++) begin
      if (src_need[i] && (src_addr[i*AW +: AW] != {AW{1'b0}})) begin
        for (int j = 0; j < NFWD; j++) begin
          if (!w_hit[i] && fwd_valid[j] && fwd_we[j] &&
              (fwd_addr[j*AW +: AW] == src_addr[i*AW +: AW])) begin
            w_hit[i]                         = 1'b1;
            w_src_data[i*DATA_WD +: DATA_WD] = fwd_data[j*DATA_WD +: DATA_WD];
            w_src_pend[i]                    = fwd_pending[j];
          end else begin
            w_hit[i] = w_hit[i];
          end
        end
      end else begin
        w_hit[i] = 1'b0;
      end
    end
  end

  // Per-source check against the destination of the in-flight MDU op.
  always_comb begin
    w_src_mdu = {NSRC{1'b0}};
    for (int i = 0; i < NSRC; i++) begin
      if (w_mdu_active && src_need[i] && (r_mdu_dst != {AW{1'b0}}) &&
          (src_addr[i*AW +: AW] == r_mdu_dst)) begin
        w_src_mdu[i] = 1'b1;
      end else begin
        w_src_mdu[i] = 1'b0;
      end
    end
  end

  // Hazard resolution and handshake terms.
  always_comb begin
    w_mdu_haz   = w_mdu_active & ((r_id_valid & is_mdu) | (|w_src_mdu));
    w_ready_go  = ~r_id_valid | ~((|w_src_pend) | w_mdu_haz);
    w_allowin   = ~r_id_valid | (w_ready_go & exe_allowin);
    w_issue     = r_id_valid & w_ready_go & exe_allowin;
    w_issue_mdu = w_issue & is_mdu;
    w_load      = w_allowin & if_to_id_valid & ~flush;
  end

  // Slot valid: flush cancels, otherwise refill whenever the slot frees up.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_id_valid <= 1'b0;
    end else if (flush) begin
      r_id_valid <= 1'b0;
    end else if (w_allowin) begin
      r_id_valid <= if_to_id_valid;
    end else begin
      r_id_valid <= r_id_valid;
    end
  end

  // Slot payload: captured only on an accepted, non-flushed transfer.
  always_ff @(posedge clk) begin
    if (w_load) begin
      r_id_data <= if_to_id_bus;
    end else begin
      r_id_data <= r_id_data;
    end
  end

  // MDU scoreboard: a new issue always reloads, otherwise count down to idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mdu_busy <= 1'b0;
      r_mdu_cnt  <= {CW{1'b0}};
      r_mdu_dst  <= {AW{1'b0}};
    end else if (w_issue_mdu) begin
      r_mdu_busy <= 1'b1;
      r_mdu_cnt  <= MDU_INIT;
      r_mdu_dst  <= dst_addr;
    end else if (r_mdu_busy) begin
      if (r_mdu_cnt == {CW{1'b0}}) begin
        r_mdu_busy <= 1'b0;
        r_mdu_cnt  <= r_mdu_cnt;
      end else begin
        r_mdu_busy <= 1'b1;
        r_mdu_cnt  <= r_mdu_cnt - CW'(1);
      end
      r_mdu_dst <= r_mdu_dst;
    end else begin
      r_mdu_busy <= 1'b0;
      r_mdu_cnt  <= r_mdu_cnt;
      r_mdu_dst  <= r_mdu_dst;
    end
  end

  // Stall counter: hazard stalls only, saturating at all-ones.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cnt <= 32'd0;
    end else if (r_id_valid && !w_ready_go && (r_stall_cnt != 32'hFFFF_FFFF)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end else begin
      r_stall_cnt <= r_stall_cnt;
    end
  end

  assign id_allowin      = w_allowin;
  assign id_to_exe_valid = r_id_valid & w_ready_go;
  assign id_data         = r_id_data;
  assign src_data        = w_src_data;
  assign id_ready_go     = w_ready_go;
  assign stall_cnt       = r_stall_cnt;

endmodule

// File: tb/tb_id_issue_ctrl.sv
// tb_id_issue_ctrl: directed self-checking bench for id_issue_ctrl.
module tb_id_issue_ctrl;

  logic          clk;
  logic          reset;
  logic          if_to_id_valid;
  logic [63:0]   if_to_id_bus;
  logic          id_allowin;
  logic          exe_allowin;
  logic          id_to_exe_valid;
  logic [63:0]   id_data;
  logic          flush;
  logic [1:0]    src_need;
  logic [9:0]    src_addr;
  logic [63:0]   src_rdata;
  logic          is_mdu;
  logic [4:0]    dst_addr;
  logic [2:0]    fwd_valid;
  logic [2:0]    fwd_we;
  logic [14:0]   fwd_addr;
  logic [95:0]   fwd_data;
  logic [2:0]    fwd_pending;
  logic [63:0]   src_data;
  logic          id_ready_go;
  logic [31:0]   stall_cnt;

  int n_checks;
  int n_errors;

  id_issue_ctrl #(
    .DATA_WD(32), .IN_WD(64), .NSRC(2), .NFWD(3), .AW(5), .MDU_LAT(4)
  ) dut (
    .clk(clk), .reset(reset),
    .if_to_id_valid(if_to_id_valid), .if_to_id_bus(if_to_id_bus),
    .id_allowin(id_allowin), .exe_allowin(exe_allowin),
    .id_to_exe_valid(id_to_exe_valid), .id_data(id_data),
    .flush(flush), .src_need(src_need), .src_addr(src_addr),
    .src_rdata(src_rdata), .is_mdu(is_mdu), .dst_addr(dst_addr),
    .fwd_valid(fwd_valid), .fwd_we(fwd_we), .fwd_addr(fwd_addr),
    .fwd_data(fwd_data), .fwd_pending(fwd_pending),
    .src_data(src_data), .id_ready_go(id_ready_go), .stall_cnt(stall_cnt)
  );

  // Free-running clock, 10 time-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset = 1'b1; if_to_id_valid = 1'b0; if_to_id_bus = 64'd0;
    exe_allowin = 1'b1; flush = 1'b0; src_need = 2'b00; src_addr = 10'd0;
    src_rdata = {32'h0000_0077, 32'h0000_0099};
    is_mdu = 1'b0; dst_addr = 5'd0;
    fwd_valid = 3'b000; fwd_we = 3'b000; fwd_addr = 15'd0;
    fwd_data = {32'h33, 32'h22, 32'h11}; fwd_pending = 3'b000;
    tick(); tick();
    reset = 1'b0;
    #1;
    chk("rst_exe_valid", {63'd0, id_to_exe_valid}, 64'd0);
    chk("rst_allowin",   {63'd0, id_allowin},      64'd1);
    chk("rst_ready_go",  {63'd0, id_ready_go},     64'd1);
    chk("rst_stall",     {32'd0, stall_cnt},       64'd0);

    // ---------------- forwarding priority ----------------
    if_to_id_bus = 64'hB100_0000_0000_0001; if_to_id_valid = 1'b1;
    tick();
    if_to_id_valid = 1'b0;
    src_need = 2'b01; src_addr = {5'd5, 5'd5};
    fwd_valid = 3'b101; fwd_we = 3'b101; fwd_addr = {5'd5, 5'd5, 5'd5};
    #1;
    chk("fwd_young",     {32'd0, src_data[31:0]},  64'h11);
    chk("fwd_src1_rf",   {32'd0, src_data[63:32]}, 64'h77);
    chk("fwd_ready",     {63'd0, id_ready_go},     64'd1);
    chk("fwd_exe_valid", {63'd0, id_to_exe_valid}, 64'd1);
    chk("fwd_id_data",   id_data,                  64'hB100_0000_0000_0001);
    fwd_valid = 3'b100; #1;
    chk("fwd_old",       {32'd0, src_data[31:0]},  64'h33);
    fwd_valid = 3'b110; fwd_we = 3'b101; #1;
    chk("fwd_skip_nowe", {32'd0, src_data[31:0]},  64'h33);
    src_need = 2'b00; #1;
    chk("fwd_notneed",   {32'd0, src_data[31:0]},  64'h99);
    src_need = 2'b01; src_addr = 10'd0; fwd_addr = 15'd0;
    fwd_valid = 3'b111; fwd_we = 3'b111; #1;
    chk("fwd_r0",        {32'd0, src_data[31:0]},  64'h99);
    src_addr = {5'd0, 5'd5}; fwd_addr = {5'd5, 5'd5, 5'd5}; fwd_pending = 3'b100; #1;
    chk("shadow_data",   {32'd0, src_data[31:0]},  64'h11);
    chk("shadow_ready",  {63'd0, id_ready_go},     64'd1);
    fwd_pending = 3'b001; #1;
    chk("pend_ready",    {63'd0, id_ready_go},     64'd0);
    chk("pend_exe",      {63'd0, id_to_exe_valid}, 64'd0);
    fwd_pending = 3'b000; fwd_valid = 3'b000; fwd_we = 3'b000;
    tick();
    chk("fwd_issued",    {63'd0, id_to_exe_valid}, 64'd0);
    chk("fwd_stall0",    {32'd0, stall_cnt},       64'd0);

    // ---------------- load-use interlock ----------------
    if_to_id_bus = 64'hB200_0000_0000_0002; if_to_id_valid = 1'b1;
    tick();
    if_to_id_valid = 1'b0;
    src_need = 2'b01; src_addr = {5'd0, 5'd7};
    fwd_valid = 3'b001; fwd_we = 3'b001; fwd_addr = {5'd0, 5'd0, 5'd7};
    fwd_pending = 3'b001; #1;
    chk("lu_ready",      {63'd0, id_ready_go},     64'd0);
    chk("lu_exe",        {63'd0, id_to_exe_valid}, 64'd0);
    chk("lu_allowin",    {63'd0, id_allowin},      64'd0);
    tick();
    fwd_pending = 3'b000; fwd_data = {32'h33, 32'h22, 32'hAB}; #1;
    chk("lu_stall1",     {32'd0, stall_cnt},       64'd1);
    chk("lu_go",         {63'd0, id_to_exe_valid}, 64'd1);
    chk("lu_data",       {32'd0, src_data[31:0]},  64'hAB);
    tick();
    if_to_id_bus = 64'hB300_0000_0000_0003; if_to_id_valid = 1'b1;
    tick();
    if_to_id_valid = 1'b0;
    src_addr = 10'd0; fwd_addr = 15'd0; fwd_pending = 3'b001; #1;
    chk("lu_r0_ready",   {63'd0, id_ready_go},     64'd1);
    chk("lu_r0_data",    {32'd0, src_data[31:0]},  64'h99);
    tick();
    chk("lu_r0_stall",   {32'd0, stall_cnt},       64'd1);
    fwd_valid = 3'b000; fwd_we = 3'b000; fwd_pending = 3'b000; src_need = 2'b00;

    // ---------------- MDU busy, dependent read ----------------
    if_to_id_bus = 64'hB400_0000_0000_0004; if_to_id_valid = 1'b1;
    is_mdu = 1'b1; dst_addr = 5'd9;
    tick();
    if_to_id_bus = 64'hB500_0000_0000_0005; #1;
    chk("mdu1_issue",    {63'd0, id_to_exe_valid}, 64'd1);
    tick();
    is_mdu = 1'b0; dst_addr = 5'd0; if_to_id_valid = 1'b0;
    src_need = 2'b01; src_addr = {5'd0, 5'd9};
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("mdu1_stall",  {63'd0, id_ready_go},     64'd0);
      tick();
    end
    chk("mdu1_go",       {63'd0, id_to_exe_valid}, 64'd1);
    chk("mdu1_id_data",  id_data,                  64'hB500_0000_0000_0005);
    chk("mdu1_stallcnt", {32'd0, stall_cnt},       64'd4);
    tick();
    src_need = 2'b00;

    // ---------------- back-to-back MDU ops ----------------
    if_to_id_bus = 64'hB600_0000_0000_0006; if_to_id_valid = 1'b1;
    is_mdu = 1'b1; dst_addr = 5'd9;
    tick();
    if_to_id_bus = 64'hB700_0000_0000_0007;
    tick();
    dst_addr = 5'd3; if_to_id_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("mdu2_stall",  {63'd0, id_ready_go},     64'd0);
      tick();
    end
    chk("mdu2_go",       {63'd0, id_to_exe_valid}, 64'd1);
    chk("mdu2_id_data",  id_data,                  64'hB700_0000_0000_0007);
    chk("mdu2_stallcnt", {32'd0, stall_cnt},       64'd7);

    // ---------------- flush while stalled ----------------
    if_to_id_bus = 64'hB800_0000_0000_0008; if_to_id_valid = 1'b1;
    tick();
    is_mdu = 1'b0; dst_addr = 5'd0; if_to_id_valid = 1'b0;
    src_need = 2'b01; src_addr = {5'd0, 5'd3}; #1;
    chk("fl_stalled",    {63'd0, id_ready_go},     64'd0);
    flush = 1'b1; if_to_id_valid = 1'b1; if_to_id_bus = 64'hB900_0000_0000_0009; #1;
    chk("fl_allowin",    {63'd0, id_allowin},      64'd0);
    tick();
    flush = 1'b0; if_to_id_valid = 1'b0; #1;
    chk("fl_exe_valid",  {63'd0, id_to_exe_valid}, 64'd0);
    chk("fl_allowin2",   {63'd0, id_allowin},      64'd1);
    chk("fl_id_data",    id_data,                  64'hB800_0000_0000_0008);
    chk("fl_stallcnt",   {32'd0, stall_cnt},       64'd8);
    if_to_id_bus = 64'hBA00_0000_0000_000A; if_to_id_valid = 1'b1;
    tick();
    if_to_id_valid = 1'b0; #1;
    chk("fl_cnt_stall",  {63'd0, id_ready_go},     64'd0);
    tick();
    chk("fl_cnt_done",   {63'd0, id_ready_go},     64'd1);
    chk("fl_stallcnt2",  {32'd0, stall_cnt},       64'd9);
    tick();
    src_need = 2'b00;

    // ---------------- backpressure then reset ----------------
    if_to_id_bus = 64'hBB00_0000_0000_000B; if_to_id_valid = 1'b1;
    is_mdu = 1'b1; dst_addr = 5'd4;
    tick();
    if_to_id_bus = 64'hBC00_0000_0000_000C; exe_allowin = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("bp_allowin",  {63'd0, id_allowin},      64'd0);
      chk("bp_id_data",  id_data,                  64'hBB00_0000_0000_000B);
      tick();
    end
    chk("bp_stallcnt",   {32'd0, stall_cnt},       64'd9);
    exe_allowin = 1'b1; #1;
    chk("bp_release",    {63'd0, id_to_exe_valid}, 64'd1);
    tick();
    is_mdu = 1'b0; dst_addr = 5'd0; if_to_id_valid = 1'b0;
    src_need = 2'b01; src_addr = {5'd0, 5'd4}; #1;
    chk("bp_mdu_stall",  {63'd0, id_ready_go},     64'd0);
    tick();
    chk("bp_stallcnt2",  {32'd0, stall_cnt},       64'd10);
    reset = 1'b1;
    tick();
    reset = 1'b0; #1;
    chk("rst2_exe",      {63'd0, id_to_exe_valid}, 64'd0);
    chk("rst2_allowin",  {63'd0, id_allowin},      64'd1);
    chk("rst2_stall",    {32'd0, stall_cnt},       64'd0);
    if_to_id_bus = 64'hBD00_0000_0000_000D; if_to_id_valid = 1'b1;
    tick();
    if_to_id_valid = 1'b0; #1;
    chk("rst2_mdu_idle", {63'd0, id_ready_go},     64'd1);
    chk("rst2_issue",    {63'd0, id_to_exe_valid}, 64'd1);
    chk("rst2_id_data",  id_data,                  64'hBD00_0000_0000_000D);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
